// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the external memory port arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (see ext_mem_arbiter.sv).
package ext_mem_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/ext_mem_arb_pick.sv
// Combinational winner select between the CPU and debug requesters.
// prefer_dbg carries either the starve-full flag or "CPU won last" (round-robin build).
module ext_mem_arb_pick
   import ext_mem_pkg::*;
(
   input  logic cpu_req,
   input  logic dbg_req,
   input  logic prefer_dbg,
   output logic winner,
   output logic any_req
);

   assign any_req = cpu_req | dbg_req;
   // CPU wins by default; debug wins when it is alone or is being favoured.
   assign winner  = (dbg_req && (!cpu_req || prefer_dbg)) ? REQ_DBG : REQ_CPU;

endmodule

// File: rtl/ext_mem_arbiter.sv
// Two-requester arbiter for the shared 6-bit external memory port (IDLE -> ADDR -> DONE).
// Define ARB_ROUND_ROBIN_EN for alternating arbitration instead of CPU priority with starve escape.
module ext_mem_arbiter
   import ext_mem_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int WAIT_CYCLES  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_gnt,
   output logic              cpu_valid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_gnt,
   output logic              dbg_valid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WC_W = $clog2(WAIT_CYCLES + 1);

   state_t          state;
   logic [WC_W-1:0] wait_cnt;
   logic            owner;
   logic            prefer_dbg;
   logic            winner;
   logic            any_req;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_win;
   assign prefer_dbg = (last_win == REQ_CPU);
`else
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   logic [SC_W-1:0] starve_cnt;
   assign prefer_dbg = (starve_cnt == SC_W'(STARVE_LIMIT));
`endif

   ext_mem_arb_pick u_pick (
      .cpu_req    (cpu_req),
      .dbg_req    (dbg_req),
      .prefer_dbg (prefer_dbg),
      .winner     (winner),
      .any_req    (any_req)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         owner     <= REQ_CPU;
         mem_addr  <= '0;
         cpu_gnt   <= 1'b0;
         dbg_gnt   <= 1'b0;
         cpu_valid <= 1'b0;
         dbg_valid <= 1'b0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_win  <= REQ_DBG;
`else
         starve_cnt <= '0;
`endif
      end else begin
         // gnt and valid are single-cycle pulses unless set again below.
         cpu_gnt   <= 1'b0;
         dbg_gnt   <= 1'b0;
         cpu_valid <= 1'b0;
         dbg_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  owner    <= winner;
                  mem_addr <= (winner == REQ_DBG) ? dbg_addr : cpu_addr;
                  wait_cnt <= '0;
                  state    <= ST_ADDR;
                  if (winner == REQ_DBG) dbg_gnt <= 1'b1;
                  else                   cpu_gnt <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                  last_win <= winner;
`else
                  // A CPU grant over a waiting debug request can only happen below the limit.
                  if (winner == REQ_DBG)
                     starve_cnt <= '0;
                  else if (dbg_req && !prefer_dbg)
                     starve_cnt <= starve_cnt + 1'b1;
`endif
               end
            end
            ST_ADDR: begin
               if (wait_cnt == WC_W'(WAIT_CYCLES - 1)) begin
                  if (owner == REQ_DBG) begin
                     dbg_rdata <= mem_rdata;
                     dbg_valid <= 1'b1;
                  end else begin
                     cpu_rdata <= mem_rdata;
                     cpu_valid <= 1'b1;
                  end
                  state <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
